// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and instruction-memory loader.
// Packs decoded field bundles into 32-bit machine words and streams them to
// consecutive instruction-memory word addresses through a one-entry output
// register, tracking how many words have landed and flagging bad bundles.
module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_illegal,
  output logic              err_align
);

  typedef enum logic [2:0] {
    K_R      = 3'd0,
    K_I      = 3'd1,
    K_LOAD   = 3'd2,
    K_STORE  = 3'd3,
    K_BRANCH = 3'd4,
    K_JAL    = 3'd5,
    K_LUI    = 3'd6,
    K_ILL    = 3'd7
  } kind_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   DEPTH_M1 = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] BASE_C   = BASE_ADDR[ADDR_W-1:0];

  state_t             state_q, state_d;
  kind_t              kind_e;
  logic [31:0]        enc_word;
  logic [31:0]        wdata_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [ADDR_W:0]    cnt_q;
  logic               err_ill_q, err_al_q;
  logic               kind_illegal, misaligned, legal;
  logic               accept, write_done;

  assign kind_e       = kind_t'(kind);
  assign kind_illegal = (kind_e == K_ILL);
  assign misaligned   = ((kind_e == K_BRANCH) || (kind_e == K_JAL)) && imm[0];
  assign legal        = !kind_illegal && !misaligned;

  assign imem_we     = (state_q == S_PEND);
  assign full        = (cnt_q == DEPTH_C) || ((cnt_q == DEPTH_M1) && imem_we);
  assign in_ready    = !clear && !full && (!imem_we || imem_ready);
  assign accept      = in_valid && in_ready;
  assign write_done  = imem_we && imem_ready;

  assign imem_addr   = ptr_q;
  assign imem_wdata  = wdata_q;
  assign count       = cnt_q;
  assign err_illegal = err_ill_q;
  assign err_align   = err_al_q;

  // Pack the incoming field bundle into its RV32I machine-word format
  always_comb begin
    enc_word = '0;
    case (kind_e)
      K_R:      enc_word = {funct7, rs2, rs1, funct3, rd, OP_R};
      K_I:      enc_word = {imm[11:0], rs1, funct3, rd, OP_I};
      K_LOAD:   enc_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      K_STORE:  enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      K_BRANCH: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
      K_JAL:    enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      K_LUI:    enc_word = {imm[31:12], rd, OP_LUI};
      default:  enc_word = '0;
    endcase
  end

  // Output-register occupancy: a legal acceptance always (re)fills it, a completed write empties it
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (accept && legal) state_d = S_PEND;
        S_PEND: begin
          if (accept && legal) state_d = S_PEND;
          else if (imem_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Write pointer, completed-word count, pending word and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdata_q   <= '0;
      ptr_q     <= BASE_C;
      cnt_q     <= '0;
      err_ill_q <= 1'b0;
      err_al_q  <= 1'b0;
    end else if (clear) begin
      wdata_q   <= '0;
      ptr_q     <= BASE_C;
      cnt_q     <= '0;
      err_ill_q <= 1'b0;
      err_al_q  <= 1'b0;
    end else begin
      if (write_done) begin
        cnt_q <= cnt_q + CNT_ONE;
        ptr_q <= ptr_q + PTR_ONE;
      end
      if (accept) begin
        if (legal)        wdata_q   <= enc_word;
        if (kind_illegal) err_ill_q <= 1'b1;
        if (misaligned)   err_al_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: a 256-word and a 4-word
// instance share stimulus; a transaction-level model predicts every output
// of both each cycle, and directed checks pin hand-computed words and events.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        imem_ready = 1'b1;
  logic [2:0]  kind = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;

  logic        in_ready_a, imem_we_a, full_a, err_ill_a, err_al_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  count_a;
  logic        in_ready_b, imem_we_b, full_b, err_ill_b, err_al_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = 256-word instance, 1 = 4-word instance
  int          depth [2] = '{256, 4};
  bit          m_pend [2];
  logic [31:0] m_word [2];
  int          m_ptr [2];
  int          m_cnt [2];
  bit          m_ill [2];
  bit          m_al [2];
  int          cyc = 0;

  int          log_a_addr[$], log_a_cyc[$];
  logic [31:0] log_a_data[$];
  int          log_b_addr[$];
  logic [31:0] log_b_data[$];

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_a),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we_a), .imem_ready(imem_ready), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .count(count_a), .full(full_a), .err_illegal(err_ill_a), .err_align(err_al_a)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_b),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we_b), .imem_ready(imem_ready), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .count(count_b), .full(full_b), .err_illegal(err_ill_b), .err_align(err_al_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Machine word from field values, built with shifts and masks
  function automatic logic [31:0] encodeRef(input logic [2:0] k, input logic [4:0] d,
                                            input logic [4:0] s1, input logic [4:0] s2,
                                            input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] im);
    logic [31:0] regs;
    regs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
    case (k)
      3'd0: return (32'(f7) << 25) | regs | (32'(d) << 7) | 32'h33;
      3'd1: return ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h13;
      3'd2: return ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7) | 32'h03;
      3'd3: return (((im >> 5) & 32'h7F) << 25) | regs | ((im & 32'h1F) << 7) | 32'h23;
      3'd4: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | regs
                   | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
      3'd5: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                   | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'h6F;
      3'd6: return (im & 32'hFFFFF000) | (32'(d) << 7) | 32'h37;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit modelFull(input int i);
    return (m_cnt[i] == depth[i]) || ((m_cnt[i] == depth[i] - 1) && m_pend[i]);
  endfunction

  function automatic bit modelReady(input int i);
    return !clear && !modelFull(i) && (!m_pend[i] || imem_ready);
  endfunction

  // Transaction-level model of both instances, advanced on each clock edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pend[i] <= 1'b0; m_word[i] <= '0; m_ptr[i] <= 0;
        m_cnt[i] <= 0; m_ill[i] <= 1'b0; m_al[i] <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (clear) begin
          m_pend[i] <= 1'b0; m_ptr[i] <= 0; m_cnt[i] <= 0;
          m_ill[i] <= 1'b0; m_al[i] <= 1'b0;
        end else begin
          if (m_pend[i] && imem_ready) begin
            m_cnt[i]  <= m_cnt[i] + 1;
            m_ptr[i]  <= (m_ptr[i] + 1) % depth[i];
            m_pend[i] <= 1'b0;
          end
          if (in_valid && modelReady(i)) begin
            if (kind == 3'd7) m_ill[i] <= 1'b1;
            else if ((kind == 3'd4 || kind == 3'd5) && imm[0]) m_al[i] <= 1'b1;
            else begin
              m_pend[i] <= 1'b1;
              m_word[i] <= encodeRef(kind, rd, rs1, rs2, funct3, funct7, imm);
            end
          end
        end
      end
    end
  end

  task automatic compareDut(input int i, input string tag, input logic rdy, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] cnt, input logic fl, input logic ill, input logic al);
    checkOutput({tag, "_in_ready"}, 32'(rdy), 32'(modelReady(i)));
    checkOutput({tag, "_imem_we"}, 32'(we), 32'(m_pend[i]));
    checkOutput({tag, "_imem_addr"}, addr, 32'(m_ptr[i]));
    if (m_pend[i]) checkOutput({tag, "_imem_wdata"}, wdata, m_word[i]);
    checkOutput({tag, "_count"}, cnt, 32'(m_cnt[i]));
    checkOutput({tag, "_full"}, 32'(fl), 32'(modelFull(i)));
    checkOutput({tag, "_err_illegal"}, 32'(ill), 32'(m_ill[i]));
    checkOutput({tag, "_err_align"}, 32'(al), 32'(m_al[i]));
  endtask

  // Every-cycle comparison of both instances against the model, away from the active edge
  always @(negedge clk) begin
    compareDut(0, "mdl_a", in_ready_a, imem_we_a, 32'(addr_a), wdata_a, 32'(count_a),
               full_a, err_ill_a, err_al_a);
    compareDut(1, "mdl_b", in_ready_b, imem_we_b, 32'(addr_b), wdata_b, 32'(count_b),
               full_b, err_ill_b, err_al_b);
  end

  // Record writes that will complete at the coming edge
  always @(negedge clk) begin
    if (rst_n && !clear && imem_ready) begin
      if (imem_we_a) begin
        log_a_addr.push_back(int'(addr_a));
        log_a_data.push_back(wdata_a);
        log_a_cyc.push_back(cyc);
      end
      if (imem_we_b) begin
        log_b_addr.push_back(int'(addr_b));
        log_b_data.push_back(wdata_b);
      end
    end
  end

  // Present one bundle and hold it until the large instance takes it
  task automatic applyStimulus(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] im);
    int n;
    kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_a && n < 40);
    if (!in_ready_a) begin
      total++;
      bad++;
      $display("[TB] FAIL handshake_timeout actual=in_ready 0 required=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulseClear();
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    int mark;

    #12 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready_a), 32'd1);
    checkOutput("rst_imem_we", 32'(imem_we_a), 32'd0);
    checkOutput("rst_imem_addr", 32'(addr_a), 32'd0);
    checkOutput("rst_imem_wdata", wdata_a, 32'd0);
    checkOutput("rst_count", 32'(count_a), 32'd0);
    checkOutput("rst_full", 32'(full_a), 32'd0);
    checkOutput("rst_err_illegal", 32'(err_ill_a), 32'd0);
    checkOutput("rst_err_align", 32'(err_al_a), 32'd0);
    @(posedge clk);
    #1;

    // add x3,x1,x2
    applyStimulus(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("add_imem_we", 32'(imem_we_a), 32'd1);
    checkOutput("add_imem_addr", 32'(addr_a), 32'd0);
    checkOutput("add_imem_wdata", wdata_a, 32'h002081B3);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("add_count", 32'(count_a), 32'd1);
    @(posedge clk);
    #1;

    // sw, beq, lui back-to-back
    pulseClear();
    mark = log_a_addr.size();
    applyStimulus(3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8);
    applyStimulus(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
    applyStimulus(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    idleCycles(3);
    checkOutput("b2b_log_len", 32'(log_a_addr.size() - mark), 32'd3);
    if (log_a_addr.size() >= mark + 3) begin
      checkOutput("b2b_word0", log_a_data[mark], 32'h00512423);
      checkOutput("b2b_word1", log_a_data[mark + 1], 32'hFE208EE3);
      checkOutput("b2b_word2", log_a_data[mark + 2], 32'h123452B7);
      checkOutput("b2b_addr0", 32'(log_a_addr[mark]), 32'd0);
      checkOutput("b2b_addr2", 32'(log_a_addr[mark + 2]), 32'd2);
      checkOutput("b2b_gap01", 32'(log_a_cyc[mark + 1] - log_a_cyc[mark]), 32'd1);
      checkOutput("b2b_gap12", 32'(log_a_cyc[mark + 2] - log_a_cyc[mark + 1]), 32'd1);
    end
    @(negedge clk);
    checkOutput("b2b_count", 32'(count_a), 32'd3);
    @(posedge clk);
    #1;

    // Backpressure: addi x7,x3,5 held for four cycles, then lui x1 follows
    imem_ready = 1'b0;
    applyStimulus(3'd1, 5'd7, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5);
    kind = 3'd6; rd = 5'd1; imm = 32'hABCDE000; in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready_a), 32'd0);
      checkOutput("bp_imem_addr", 32'(addr_a), 32'd3);
      checkOutput("bp_imem_wdata", wdata_a, 32'h00518393);
    end
    imem_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_next_we", 32'(imem_we_a), 32'd1);
    checkOutput("bp_next_addr", 32'(addr_a), 32'd4);
    checkOutput("bp_next_wdata", wdata_a, 32'hABCDE0B7);
    @(posedge clk);
    #1;
    idleCycles(2);

    // Illegal kind and misaligned branch
    applyStimulus(3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0);
    applyStimulus(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h5);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bad_imem_we", 32'(imem_we_a), 32'd0);
    checkOutput("bad_err_illegal", 32'(err_ill_a), 32'd1);
    checkOutput("bad_err_align", 32'(err_al_a), 32'd1);
    checkOutput("bad_count", 32'(count_a), 32'd5);
    @(posedge clk);
    #1;

    // Fill the 4-word instance
    pulseClear();
    mark = log_b_addr.size();
    applyStimulus(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    applyStimulus(3'd2, 5'd2, 5'd1, 5'd0, 3'd2, 7'd0, 32'd4);
    applyStimulus(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    applyStimulus(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    applyStimulus(3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8);
    idleCycles(3);
    checkOutput("full_log_len", 32'(log_b_addr.size() - mark), 32'd4);
    if (log_b_addr.size() >= mark + 4) begin
      checkOutput("full_word0", log_b_data[mark], 32'h00100093);
      checkOutput("full_word1", log_b_data[mark + 1], 32'h0040A103);
      checkOutput("full_word2", log_b_data[mark + 2], 32'h001000EF);
      checkOutput("full_addr3", 32'(log_b_addr[mark + 3]), 32'd3);
    end
    @(negedge clk);
    checkOutput("full_count", 32'(count_b), 32'd4);
    checkOutput("full_flag", 32'(full_b), 32'd1);
    checkOutput("full_in_ready", 32'(in_ready_b), 32'd0);
    checkOutput("full_imem_we", 32'(imem_we_b), 32'd0);
    @(posedge clk);
    #1;

    // clear while a word is pending under backpressure
    applyStimulus(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    imem_ready = 1'b0;
    applyStimulus(3'd0, 5'd9, 5'd8, 5'd7, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("clr_pre_we", 32'(imem_we_a), 32'd1);
    @(posedge clk);
    #1;
    pulseClear();
    @(negedge clk);
    checkOutput("clr_imem_we", 32'(imem_we_a), 32'd0);
    checkOutput("clr_count", 32'(count_a), 32'd0);
    checkOutput("clr_err_illegal", 32'(err_ill_a), 32'd0);
    checkOutput("clr_imem_addr", 32'(addr_a), 32'd0);
    checkOutput("clr_full_b", 32'(full_b), 32'd0);
    checkOutput("clr_count_b", 32'(count_b), 32'd0);
    @(posedge clk);
    #1;
    imem_ready = 1'b1;
    applyStimulus(3'd0, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("clr_next_addr", 32'(addr_a), 32'd0);
    checkOutput("clr_next_wdata", wdata_a, 32'h40628233);
    @(posedge clk);
    #1;
    idleCycles(2);

    // Reset asserted mid-write
    imem_ready = 1'b0;
    applyStimulus(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_imem_we", 32'(imem_we_a), 32'd0);
    checkOutput("arst_imem_addr", 32'(addr_a), 32'd0);
    checkOutput("arst_imem_wdata", wdata_a, 32'd0);
    checkOutput("arst_count", 32'(count_a), 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    imem_ready = 1'b1;
    idleCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
